clock_display_mux: RTL and testbench
====================================

// Module: clock_display_mux
// PURPOSE
//  Downstream of the clock controller. Drives the Basys3 4-digit, active-low, common-anode
//  7-segment display from the six BCD time digits, the AM/PM bit and the alarm flag.
//  Time-multiplexes one digit per scan slot. Shows HH:MM or MM:SS, chosen by show_sec.
//  Samples its inputs once per frame, so a displayed frame never mixes two time values.
// PARAMETERS
//  DIGIT_TICKS  100_000     clk cycles per digit slot (1 ms at 100 MHz)
//  BLINK_TICKS  25_000_000  clk cycles per blink half-period (250 ms); used only with the macro
// PORTS
//  clk         in   1  system clock, 100 MHz
//  rst_n       in   1  synchronous reset, active-low
//  hour2,hour1 in   4  hour tens/units, BCD (1..12)
//  min2,min1   in   4  minute tens/units, BCD
//  sec2,sec1   in   4  second tens/units, BCD
//  ampm        in   1  1 = PM
//  alarm_flag  in   1  alarm currently asserted
//  show_sec    in   1  0 = HH:MM, 1 = MM:SS
//  seg         out  7  {g,f,e,d,c,b,a}, active-low
//  dp          out  1  decimal point, active-low
//  an          out  4  digit anodes, active-low; an[0] = rightmost digit
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge clk): an=4'b1111, seg=7'h7F, dp=1.
//    Slot counter, scan index, blink counter and phase = 0. Shadow registers = 0.
//  - Tick: tick_cnt counts 0..DIGIT_TICKS-1. tick=1 on the cycle where it equals DIGIT_TICKS-1.
//    On tick the scan index idx increments mod 4 (3 wraps to 0).
//  - Frame snapshot: on a tick with idx==3 (the wrap cycle), load every input into shadow registers.
//    All decoding uses shadow values only. First valid frame starts at the first wrap after reset.
//  - Outputs are registered and update on the cycle following tick. Exactly one an bit is low.
//  - Digit map for idx 3..0:
//    HH:MM: hour2, hour1, min2, min1.
//    MM:SS: min2, min1, sec2, sec1.
//  - Blanking:
//    HH:MM with hour2==0 → digit 3 seg=7'h7F, anode still driven.
//    MM:SS: no blanking.
//  - Decimal point:
//    dp=0 on idx 2 in both modes (colon substitute).
//    dp=0 on idx 0 only in HH:MM with ampm=1.
//    Otherwise dp=1.
//  - Decode: 0→7'b1000000, 1→7'b1111001, 2→7'b0100100, 3→7'b0110000, 4→7'b0011001,
//    5→7'b0010010, 6→7'b0000010, 7→7'b1111000, 8→7'b0000000, 9→7'b0010000.
//    Values 10..15 → dash 7'b0111111.
//  - Mode change mid-frame: takes effect at the next frame boundary, never mid-frame.
//  - Reset asserted mid-scan: outputs return to reset values on the next clk edge.
//    Scanning restarts at idx 0.
// CONFIGURATION
//  ALARM_BLINK_EN defined:
//    - While shadow alarm_flag=1, blink_cnt runs 0..BLINK_TICKS-1 and phase toggles at wrap.
//    - phase=1 → an forced to 4'b1111; seg and dp are unchanged.
//    - Shadow alarm_flag=0 → blink_cnt=0 and phase=0 on the next cycle, so the display is visible.
//  ALARM_BLINK_EN undefined:
//    - alarm_flag is ignored and no blink logic is generated. an is never force-blanked.
// STRUCTURE
//  - Package clock_disp_pkg holds:
//    - SEG_0..SEG_9, SEG_DASH and SEG_BLANK constants;
//    - the digit-index typedef (2 bits);
//    - mode encodings MODE_HHMM=0 and MODE_MMSS=1.
//  - Sub-module bcd_to_seg7 (combinational, 4-bit in, 7-bit out). The decode table above lives there.
//  - Top level holds the tick counter, scan index, shadow registers, blink logic and output registers.
// TESTING  (DIGIT_TICKS=4, BLINK_TICKS=16)
//  1. Reset held 3 cycles → an=1111, seg=7F, dp=1.
//     After release, an walks 1110,1101,1011,0111, each held for 4 cycles.
//  2. Inputs 10:37:xx, ampm=1, show_sec=0 → after first wrap:
//     idx3 seg=1111001, idx2 1000000 with dp=0, idx1 0110000, idx0 1111000 with dp=0.
//  3. Inputs 09:05:42, show_sec=0 → digit 3 blank (7F).
//     show_sec=1 → digits 0,5,4,2; digit 3 shows 1000000; change appears only after the next wrap.
//  4. min1 changed while idx=1 → displayed min1 is unchanged until idx wraps 3→0.
//     min1=4'hC → dash 0111111.
//  5. ALARM_BLINK_EN with alarm_flag=1 → an=1111 for 16 cycles, then scanning for 16 cycles, repeating.
//     Drop alarm_flag → scanning resumes at the next wrap, with no blank phase.
//  6. rst_n pulsed low while idx=2 → next edge an=1111.
//     After release, idx restarts at 0 with an=1110.

Source files
------------

// File: rtl/clock_display_mux_pkg.sv
// Shared constants and types for the 4-digit clock display multiplexer.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package clock_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic MODE_HHMM = 1'b0;
  localparam logic MODE_MMSS = 1'b1;

  typedef logic [1:0] digit_idx_t;

  // Per-frame copy of the time inputs; decoding never looks at the live inputs.
  typedef struct packed {
    logic [3:0] hour2;
    logic [3:0] hour1;
    logic [3:0] min2;
    logic [3:0] min1;
    logic [3:0] sec2;
    logic [3:0] sec1;
    logic       ampm;
    logic       show_sec;
  } time_snap_t;

  function automatic logic [3:0] anode_onehot_n(digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/clock_display_mux_if.sv
// Time-in / display-out bundle of the clock display multiplexer.
// master drives the time digits and observes the display; slave is the multiplexer.
interface clock_display_mux_if;
  logic [3:0] hour2;
  logic [3:0] hour1;
  logic [3:0] min2;
  logic [3:0] min1;
  logic [3:0] sec2;
  logic [3:0] sec1;
  logic       ampm;
  logic       alarm_flag;
  logic       show_sec;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  modport master (
    output hour2, hour1, min2, min1, sec2, sec1, ampm, alarm_flag, show_sec,
    input  seg, dp, an
  );

  modport slave (
    input  hour2, hour1, min2, min1, sec2, sec1, ampm, alarm_flag, show_sec,
    output seg, dp, an
  );
endinterface

// File: rtl/clock_display_mux_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
  import clock_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/clock_display_mux.sv
// Scans six BCD time digits onto a 4-digit common-anode display, one frame per snapshot.
// Define ALARM_BLINK_EN to blank the anodes periodically while the alarm is asserted.
module clock_display_mux
  import clock_disp_pkg::*;
#(
  parameter int unsigned DIGIT_TICKS = 100_000,
  parameter int unsigned BLINK_TICKS = 25_000_000
) (
  input logic                 clk,
  input logic                 rst_n,
  clock_display_mux_if.slave  disp
);

  localparam int unsigned TICK_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(DIGIT_TICKS - 1);

  logic [TICK_W-1:0] tick_cnt_q;
  digit_idx_t        idx_q;
  time_snap_t        snap_q, snap_d;
  logic              tick, frame_wrap;

  assign tick       = (tick_cnt_q == TICK_MAX);
  assign frame_wrap = tick && (idx_q == 2'd3);

  always_comb begin
    snap_d = '{
      hour2:    disp.hour2,
      hour1:    disp.hour1,
      min2:     disp.min2,
      min1:     disp.min1,
      sec2:     disp.sec2,
      sec1:     disp.sec1,
      ampm:     disp.ampm,
      show_sec: disp.show_sec
    };
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      idx_q      <= '0;
      snap_q     <= '0;
    end else begin
      if (tick) begin
        tick_cnt_q <= '0;
        idx_q      <= idx_q + 2'd1;
      end else begin
        tick_cnt_q <= tick_cnt_q + TICK_W'(1);
      end
      if (frame_wrap) snap_q <= snap_d;
    end
  end

  logic force_blank;

`ifdef ALARM_BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_TICKS - 1);

  logic [BLINK_W-1:0] blink_cnt_q;
  logic               phase_q;
  logic               alarm_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      if (frame_wrap) alarm_q <= disp.alarm_flag;
      if (alarm_q) begin
        if (blink_cnt_q == BLINK_MAX) begin
          blink_cnt_q <= '0;
          phase_q     <= ~phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
        end
      end else begin
        blink_cnt_q <= '0;
        phase_q     <= 1'b0;
      end
    end
  end

  // Gate with alarm_q so a dropped alarm shows the display from the very first slot.
  assign force_blank = phase_q && alarm_q;
`else
  logic unused_alarm_flag;
  assign unused_alarm_flag = disp.alarm_flag;
  assign force_blank       = 1'b0;
`endif

  logic [3:0] digit;
  logic       digit_blank;
  logic       dp_d;
  logic [6:0] dec_seg;
  logic [6:0] seg_d;
  logic [3:0] an_d;

  always_comb begin
    digit       = '0;
    digit_blank = 1'b0;
    if (snap_q.show_sec == MODE_MMSS) begin
      unique case (idx_q)
        2'd3: digit = snap_q.min2;
        2'd2: digit = snap_q.min1;
        2'd1: digit = snap_q.sec2;
        2'd0: digit = snap_q.sec1;
      endcase
    end else begin
      unique case (idx_q)
        2'd3: begin
          digit       = snap_q.hour2;
          digit_blank = (snap_q.hour2 == 4'd0);
        end
        2'd2: digit = snap_q.hour1;
        2'd1: digit = snap_q.min2;
        2'd0: digit = snap_q.min1;
      endcase
    end
  end

  bcd_to_seg7 u_bcd_to_seg7 (
    .bcd (digit),
    .seg (dec_seg)
  );

  always_comb begin
    seg_d = digit_blank ? SEG_BLANK : dec_seg;
    // Digit 2 dp stands in for the colon; digit 0 dp marks PM in HH:MM.
    dp_d  = !((idx_q == 2'd2) ||
              ((idx_q == 2'd0) && (snap_q.show_sec == MODE_HHMM) && snap_q.ampm));
    an_d  = force_blank ? 4'b1111 : anode_onehot_n(idx_q);
  end

  logic [6:0] seg_q;
  logic       dp_q;
  logic [3:0] an_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
      an_q  <= 4'b1111;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign disp.seg = seg_q;
  assign disp.dp  = dp_q;
  assign disp.an  = an_q;

endmodule

// File: tb/tb_clock_display_mux.sv
// Self-checking bench for clock_display_mux: vector table, directed corner sequences and
// randomized inputs checked against a frame-level reference model.
module tb_clock_display_mux;

  localparam int unsigned DT    = 4;
  localparam int unsigned BT    = 16;
  localparam int unsigned FRAME = 4 * DT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clock_display_mux_if disp ();

  clock_display_mux #(
    .DIGIT_TICKS (DT),
    .BLINK_TICKS (BT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .disp  (disp)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] h2, h1, m2, m1, s2, s1;
    logic       ampm;
    logic       ss;
    logic       alarm;
  } snap_t;

  // Model: edges since reset release, latest frame snapshot, edges spent with alarm set.
  int    k;
  int    run;
  int    last_slot;
  snap_t snap;

  typedef struct packed {
    logic [3:0]      h2, h1, m2, m1, s2, s1;
    logic            ampm;
    logic            ss;
    logic [3:0][6:0] seg;  // index = digit slot
    logic [3:0]      dp;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_time(input logic [3:0] h2, h1, m2, m1, s2, s1,
                          input logic ampm, input logic ss);
    disp.hour2 = h2; disp.hour1 = h1; disp.min2 = m2; disp.min1 = m1;
    disp.sec2  = s2; disp.sec1  = s1; disp.ampm = ampm; disp.show_sec = ss;
  endtask

  // One clock edge: predict, clock, compare, advance the model.
  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] dig;
    int         slot;
    if (!rst_n) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      slot      = (k / DT) % 4;
      last_slot = slot;
      if (snap.ss) dig = (slot == 3) ? snap.m2 : (slot == 2) ? snap.m1 :
                         (slot == 1) ? snap.s2 : snap.s1;
      else         dig = (slot == 3) ? snap.h2 : (slot == 2) ? snap.h1 :
                         (slot == 1) ? snap.m2 : snap.m1;
      e_seg = (!snap.ss && slot == 3 && snap.h2 == 4'd0) ? 7'h7F : seg_of(dig);
      e_dp  = !(slot == 2 || (slot == 0 && !snap.ss && snap.ampm));
      e_an  = 4'hF ^ (4'b0001 << slot);
`ifdef ALARM_BLINK_EN
      if (snap.alarm && ((run / BT) % 2 == 1)) e_an = 4'hF;
`endif
    end
    @(posedge clk);
    #1;
    check("model an", disp.an, e_an);
    check("model seg", disp.seg, e_seg);
    check("model dp", disp.dp, e_dp);
    if (!rst_n) begin
      k = 0; run = 0; snap = '0;
    end else begin
      run = snap.alarm ? run + 1 : 0;
      if (k % FRAME == FRAME - 1)
        snap = '{disp.hour2, disp.hour1, disp.min2, disp.min1, disp.sec2, disp.sec1,
                 disp.ampm, disp.show_sec, disp.alarm_flag};
      k++;
    end
  endtask

  // Clock through the next wrap so the current inputs are the displayed frame.
  task automatic sync_frame();
    do step(); while (k % FRAME != 0);
  endtask

  logic [3:0] walk[4];
  logic [6:0] old_frame[4];
  logic [6:0] new_frame[4];
  int         blanks;

  initial begin
    k = 0; run = 0; snap = '0; last_slot = 0;
    tbl[0] = '{4'h1, 4'h0, 4'h3, 4'h7, 4'h0, 4'h0, 1'b1, 1'b0,
               {7'b1111001, 7'b1000000, 7'b0110000, 7'b1111000}, 4'b1010};
    tbl[1] = '{4'h0, 4'h9, 4'h0, 4'h5, 4'h4, 4'h2, 1'b0, 1'b0,
               {7'b1111111, 7'b0010000, 7'b1000000, 7'b0010010}, 4'b1011};
    tbl[2] = '{4'h0, 4'h9, 4'h0, 4'h5, 4'h4, 4'h2, 1'b1, 1'b1,
               {7'b1000000, 7'b0010010, 7'b0011001, 7'b0100100}, 4'b1011};
    tbl[3] = '{4'h1, 4'h2, 4'h5, 4'hC, 4'h0, 4'h0, 1'b0, 1'b0,
               {7'b1111001, 7'b0100100, 7'b0010010, 7'b0111111}, 4'b1011};
    tbl[4] = '{4'h1, 4'h1, 4'h5, 4'h9, 4'h3, 4'h8, 1'b1, 1'b1,
               {7'b0010010, 7'b0010000, 7'b0110000, 7'b0000000}, 4'b1011};
    tbl[5] = '{4'h0, 4'h6, 4'h4, 4'h8, 4'h1, 4'h7, 1'b1, 1'b0,
               {7'b1111111, 7'b0000010, 7'b0011001, 7'b0000000}, 4'b1010};
    tbl[6] = '{4'h0, 4'h0, 4'h0, 4'h7, 4'hA, 4'h1, 1'b0, 1'b1,
               {7'b1000000, 7'b1111000, 7'b0111111, 7'b1111001}, 4'b1011};
    tbl[7] = '{4'hF, 4'hE, 4'h9, 4'h9, 4'h0, 4'h0, 1'b1, 1'b0,
               {7'b0111111, 7'b0111111, 7'b0010000, 7'b0010000}, 4'b1010};
    walk = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    set_time(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    disp.alarm_flag = 1'b0;

    // Reset held, then the anode walk from slot 0.
    rst_n = 1'b0;
    repeat (3) step();
    check("reset an", disp.an, 4'hF);
    rst_n = 1'b1;
    for (int c = 0; c < int'(FRAME); c++) begin
      step();
      check("walk an", disp.an, walk[c / DT]);
    end

    // Vector table: each entry shown for a full frame after its snapshot.
    for (int i = 0; i < 8; i++) begin
      set_time(tbl[i].h2, tbl[i].h1, tbl[i].m2, tbl[i].m1, tbl[i].s2, tbl[i].s1,
               tbl[i].ampm, tbl[i].ss);
      sync_frame();
      for (int c = 0; c < int'(FRAME); c++) begin
        step();
        check($sformatf("vec%0d seg", i), disp.seg, tbl[i].seg[last_slot]);
        check($sformatf("vec%0d dp", i), disp.dp, tbl[i].dp[last_slot]);
      end
    end

    // Digit and mode change mid-frame only show after the next wrap.
    set_time(4'h1, 4'h0, 4'h3, 4'h7, 4'h4, 4'h2, 1'b0, 1'b0);
    sync_frame();
    repeat (DT) step();
    disp.min1     = 4'hC;
    disp.show_sec = 1'b1;
    old_frame = '{7'b1111000, 7'b0110000, 7'b1000000, 7'b1111001};
    new_frame = '{7'b0100100, 7'b0011001, 7'b0111111, 7'b0110000};
    for (int c = int'(DT); c < int'(FRAME); c++) begin
      step();
      check("hold old frame", disp.seg, old_frame[last_slot]);
    end
    for (int c = 0; c < int'(FRAME); c++) begin
      step();
      check("new frame", disp.seg, new_frame[last_slot]);
    end

`ifdef ALARM_BLINK_EN
    disp.alarm_flag = 1'b0;
    sync_frame();
    disp.alarm_flag = 1'b1;
    sync_frame();
    blanks = 0;
    for (int c = 0; c < 4 * int'(BT); c++) begin
      step();
      if (disp.an == 4'hF) blanks++;
    end
    check("blink blank count", blanks, 2 * BT);
    disp.alarm_flag = 1'b0;
    sync_frame();
    blanks = 0;
    for (int c = 0; c < 2 * int'(BT); c++) begin
      step();
      if (disp.an == 4'hF) blanks++;
    end
    check("alarm off blanks", blanks, 0);
`endif

    // Reset pulse in slot 2, then restart at slot 0.
    while ((k % FRAME) != 2 * DT + 1) step();
    rst_n = 1'b0;
    step();
    check("mid reset an", disp.an, 4'hF);
    check("mid reset seg", disp.seg, 7'h7F);
    rst_n = 1'b1;
    step();
    check("restart an", disp.an, 4'b1110);

    // Randomized inputs, including non-BCD codes and alarm toggling.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 8))
          0: disp.hour2      = 4'($urandom_range(0, 15));
          1: disp.hour1      = 4'($urandom_range(0, 15));
          2: disp.min2       = 4'($urandom_range(0, 15));
          3: disp.min1       = 4'($urandom_range(0, 15));
          4: disp.sec2       = 4'($urandom_range(0, 15));
          5: disp.sec1       = 4'($urandom_range(0, 15));
          6: disp.ampm       = 1'($urandom_range(0, 1));
          7: disp.show_sec   = 1'($urandom_range(0, 1));
          default: disp.alarm_flag = 1'($urandom_range(0, 1));
        endcase
      end
      if (c % 8 == 0 && $urandom_range(0, 3) == 0) disp.hour2 = 4'h0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
